// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way, 8-set write-back cache controller.
// Contents:
//   cache_state_e - controller FSM states
//   data_sel_e    - data-array input source select
//   paddr_sel_e   - physical-memory address source select
//   NUM_WAYS, NUM_SETS - cache geometry
package cache_pkg;

  localparam int NUM_WAYS = 2;
  localparam int NUM_SETS = 8;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_e;

  typedef enum logic {
    DSEL_CPU  = 1'b0,
    DSEL_PMEM = 1'b1
  } data_sel_e;

  typedef enum logic {
    PADDR_CPU    = 1'b0,
    PADDR_VICTIM = 1'b1
  } paddr_sel_e;

endpackage

// File: rtl/cache_victim_sel.sv
// Replacement-way chooser for a 2-way set.
// Ports:
//   valid  in  2  per-way valid bits of the indexed set
//   lru    in  1  least-recently-used way of the indexed set
//   victim out 1  way to replace: lowest invalid way, else the LRU way
module cache_victim_sel
  import cache_pkg::*;
(
  input  logic [NUM_WAYS-1:0] valid,
  input  logic                lru,
  output logic                victim
);

  always_comb begin
    victim = lru;
    if (!valid[0])      victim = 1'b0;
    else if (!valid[1]) victim = 1'b1;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Control FSM for the 2-way, 8-set write-back cache. Evaluates hit/miss for
// CPU requests, sequences write-back and refill on the pmem port, and drives
// all array load strobes and datapath mux selects.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   mem_read, mem_write, mem_resp CPU request / completion (write wins)
//   hit, valid, dirty, lru        indexed-set status from the datapath
//   load_valid/dirty/tag/data     per-way array write strobes
//   valid_in, dirty_in            valid/dirty array write data
//   load_lru, lru_in              LRU array write strobe / data
//   data_sel                      0 = CPU merged write, 1 = pmem line
//   way_sel                       way driving the read/write-back mux
//   pmem_addr_sel                 0 = CPU address, 1 = {victim tag, set}
//   pmem_read, pmem_write         memory strobes, held until pmem_resp
//   pmem_resp                     single-cycle memory completion
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  input  logic [WAYS-1:0] hit,
  input  logic [WAYS-1:0] valid,
  input  logic [WAYS-1:0] dirty,
  input  logic            lru,
  output logic [WAYS-1:0] load_valid,
  output logic [WAYS-1:0] load_dirty,
  output logic [WAYS-1:0] load_tag,
  output logic [WAYS-1:0] load_data,
  output logic            valid_in,
  output logic            dirty_in,
  output logic            load_lru,
  output logic            lru_in,
  output logic            data_sel,
  output logic            way_sel,
  output logic            pmem_addr_sel,
  output logic            pmem_read,
  output logic            pmem_write,
  input  logic            pmem_resp
);

  cache_state_e state_q, state_d;
  logic         victim_q;
  logic         victim;
  logic         req;
  logic         hit_any;
  logic         hit_way;
  logic [1:0]   hit_oh;
  logic [1:0]   victim_oh;
  logic         victim_dirty;
  logic         miss_latch;

  cache_victim_sel u_victim_sel (
    .valid  (valid),
    .lru    (lru),
    .victim (victim)
  );

  assign req          = mem_read | mem_write;
  assign hit_any      = |hit;
  // Both hit bits set is illegal; resolve towards way 0.
  assign hit_way      = ~hit[0];
  assign hit_oh       = hit_way ? 2'b10 : 2'b01;
  assign victim_oh    = victim_q ? 2'b10 : 2'b01;
  assign victim_dirty = valid[victim] & dirty[victim];
  assign miss_latch   = (state_q == CHECK) && req && !hit_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CHECK;
      victim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_latch) victim_q <= victim;
    end
  end

  // Everything is gated by rst_n so a reset mid-transaction drops the
  // pmem strobes in the same instant, not at the next edge.
  always_comb begin
    state_d       = state_q;
    mem_resp      = 1'b0;
    load_valid    = '0;
    load_dirty    = '0;
    load_tag      = '0;
    load_data     = '0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    data_sel      = DSEL_CPU;
    way_sel       = 1'b0;
    pmem_addr_sel = PADDR_CPU;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        CHECK: begin
          if (req) begin
            if (hit_any) begin
              mem_resp = 1'b1;
              way_sel  = hit_way;
              load_lru = 1'b1;
              lru_in   = ~hit_way;
              if (mem_write) begin
                load_data  = hit_oh;
                data_sel   = DSEL_CPU;
                load_dirty = hit_oh;
                dirty_in   = 1'b1;
              end
            end else begin
              state_d = victim_dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = PADDR_VICTIM;
          way_sel       = victim_q;
          if (pmem_resp) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          // hit may rise here through write-forwarding; mem_resp waits for CHECK.
          pmem_read     = 1'b1;
          pmem_addr_sel = PADDR_CPU;
          if (pmem_resp) begin
            load_data  = victim_oh;
            load_tag   = victim_oh;
            load_valid = victim_oh;
            valid_in   = 1'b1;
            load_dirty = victim_oh;
            dirty_in   = 1'b0;
            data_sel   = DSEL_PMEM;
            state_d    = CHECK;
          end
        end
        default: state_d = CHECK;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, mem_write, mem_resp;
  logic [1:0] hit, valid, dirty;
  logic       lru;
  logic [1:0] load_valid, load_dirty, load_tag, load_data;
  logic       valid_in, dirty_in, load_lru, lru_in, data_sel, way_sel;
  logic       pmem_addr_sel, pmem_read, pmem_write, pmem_resp;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [17:0] vec;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cache_ctrl #(.WAYS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .valid(valid), .dirty(dirty), .lru(lru),
    .load_valid(load_valid), .load_dirty(load_dirty),
    .load_tag(load_tag), .load_data(load_data),
    .valid_in(valid_in), .dirty_in(dirty_in),
    .load_lru(load_lru), .lru_in(lru_in),
    .data_sel(data_sel), .way_sel(way_sel), .pmem_addr_sel(pmem_addr_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
  );

  wire [17:0] obs = {mem_resp, load_valid, load_dirty, load_tag, load_data,
                     valid_in, dirty_in, load_lru, lru_in, data_sel, way_sel,
                     pmem_addr_sel, pmem_read, pmem_write};

  // Expected-output builder; argument order matches obs.
  function automatic logic [17:0] mk(
    input logic resp, input logic [1:0] lv, input logic [1:0] ld,
    input logic [1:0] lt, input logic [1:0] ldat, input logic vin,
    input logic din, input logic llru, input logic lin, input logic dsel,
    input logic wsel, input logic pas, input logic pr, input logic pw);
    return {resp, lv, ld, lt, ldat, vin, din, llru, lin, dsel, wsel, pas, pr, pw};
  endfunction

  localparam logic [17:0] IDLE = 18'h0;

  task automatic drive(input logic rd, input logic wr, input logic [1:0] h,
                       input logic [1:0] v, input logic [1:0] d,
                       input logic l, input logic pr);
    mem_read = rd; mem_write = wr; hit = h; valid = v; dirty = d;
    lru = l; pmem_resp = pr;
  endtask

  // Inputs are already applied at the negedge; compare mid-low-phase,
  // then let one rising edge pass.
  task automatic expect_cycle(input string name, input logic [17:0] e,
                              input bit advance = 1);
    exp_t x, got;
    x.name = name; x.vec = e;
    sb.push_back(x);
    #2;
    got = sb.pop_front();
    total++;
    if (obs !== got.vec)
      $display("FAIL %s: observed %b required %b", got.name, obs, got.vec);
    else passed++;
    if (advance) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 0, 2'b01, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    expect_cycle("reset_outputs_zero", IDLE);
    drive(0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    expect_cycle("reset_release_idle", IDLE);
  endtask

  task automatic test_read_hit();
    drive(1, 0, 2'b10, 2'b11, 2'b00, 1, 0);
    expect_cycle("read_hit_way1",
      mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
  endtask

  task automatic test_write_hit();
    drive(0, 1, 2'b01, 2'b11, 2'b00, 0, 0);
    expect_cycle("write_hit_way0",
      mk(1, 0, 2'b01, 0, 2'b01, 0, 1, 1, 1, 0, 0, 0, 0, 0));
  endtask

  task automatic test_clean_miss();
    drive(1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    expect_cycle("clean_miss_check", IDLE);
    drive(1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    expect_cycle("alloc_wait1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    expect_cycle("alloc_wait2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(1, 0, 2'b10, 2'b11, 2'b00, 0, 1);
    expect_cycle("alloc_fill_way1",
      mk(0, 2'b10, 2'b10, 2'b10, 2'b10, 1, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(1, 0, 2'b10, 2'b11, 2'b00, 0, 0);
    expect_cycle("clean_miss_resp",
      mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
  endtask

  task automatic test_dirty_miss();
    drive(0, 1, 2'b00, 2'b11, 2'b01, 0, 0);
    expect_cycle("dirty_miss_check", IDLE);
    expect_cycle("wb_wait", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    pmem_resp = 1;
    expect_cycle("wb_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    drive(0, 1, 2'b01, 2'b11, 2'b01, 0, 1);
    expect_cycle("alloc_fill_way0",
      mk(0, 2'b01, 2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(0, 1, 2'b01, 2'b11, 2'b00, 0, 0);
    expect_cycle("dirty_miss_write_hit",
      mk(1, 0, 2'b01, 0, 2'b01, 0, 1, 1, 1, 0, 0, 0, 0, 0));
  endtask

  task automatic test_drop_in_writeback();
    // Victim is the dirty LRU way 1.
    drive(1, 0, 2'b00, 2'b11, 2'b10, 1, 0);
    expect_cycle("drop_check", IDLE);
    drive(0, 0, 2'b00, 2'b11, 2'b10, 1, 0);
    expect_cycle("drop_wb_way1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    pmem_resp = 1;
    expect_cycle("drop_wb_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    pmem_resp = 0;
    expect_cycle("drop_alloc_wait", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    pmem_resp = 1;
    expect_cycle("drop_alloc_fill",
      mk(0, 2'b10, 2'b10, 2'b10, 2'b10, 1, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(0, 0, 2'b10, 2'b11, 2'b00, 0, 0);
    expect_cycle("drop_back_idle", IDLE);
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 2'b01, 2'b11, 2'b00, 0, 0);
    expect_cycle("b2b_read_way0", mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    drive(1, 1, 2'b10, 2'b11, 2'b00, 0, 0);
    expect_cycle("b2b_rw_write_wins",
      mk(1, 0, 2'b10, 0, 2'b10, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    drive(1, 0, 2'b11, 2'b11, 2'b00, 0, 1);
    expect_cycle("b2b_double_hit_way0", mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
  endtask

  task automatic test_invalid_victim();
    // Both ways invalid with lru=1: lowest invalid way (0) must be chosen.
    drive(1, 0, 2'b00, 2'b00, 2'b11, 1, 0);
    expect_cycle("inv_miss_check", IDLE);
    pmem_resp = 1;
    expect_cycle("inv_fill_way0",
      mk(0, 2'b01, 2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    expect_cycle("resp_in_check_ignored", IDLE);
  endtask

  task automatic test_reset_mid_allocate();
    drive(1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    expect_cycle("rma_check", IDLE);
    expect_cycle("rma_alloc", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0);
    #1 rst_n = 1'b0;
    expect_cycle("rma_reset_immediate", IDLE);
    drive(0, 0, 2'b00, 2'b01, 2'b00, 0, 1);
    rst_n = 1'b1;
    expect_cycle("rma_late_resp_no_load", IDLE);
    pmem_resp = 0;
    drive(1, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    expect_cycle("rma_state_check_hit", mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_drop_in_writeback();
    test_back_to_back();
    test_invalid_victim();
    test_reset_mid_allocate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
